// File: rtl/ram_pkg.sv
// Shared definitions for byte_lane_ram: funct3 codes, FSM encoding and
// the store byte-mask helper.
package ram_pkg;

    // RV load/store funct3: [1:0] = log2(size in bytes), [2] = zero-extend
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Contiguous byte-enable mask of 2**size bytes starting at lane (8 lanes max)
    function automatic logic [7:0] mask(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Byte-enabled synchronous RAM: one write port, one read port with
// registered output.
// Ports: clk; we/be/waddr/wdata write port; re/raddr/rdata read port.
module ram_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter string       FILE_NAME  = "",
    localparam int unsigned NB        = DATA_WIDTH / 8,
    localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [NB-1:0]         be,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Per-lane write; read data registered
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/byte_lane_ram.sv
// RV load/store data memory: byte-lane stores, sign/zero-extended sub-word
// loads, valid/ready request and response handshakes, error flagging.
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_we/req_addr/
// req_funct3/req_wdata request; rsp_valid/rsp_ready/rsp_rdata/rsp_err response.
module byte_lane_ram
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter logic [31:0] ADDR_BASE  = 32'h0,
    parameter string       FILE_NAME  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LW = $clog2(NB);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t state, state_d;

    logic [31:0]           off;
    logic [31:0]           word_idx;
    logic [LW-1:0]         lane;
    logic [1:0]            size;
    logic                  range_err, align_err, f3_err, err_c;
    logic                  acc_c, we_c, re_c;
    logic [NB-1:0]         be_c;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] bank_rdata;

    logic [LW-1:0]         lane_q;
    logic [2:0]            f3_q;

    logic [DATA_WIDTH-1:0] shifted, ext;
    logic                  msb, fill;
    int                    nb;

    logic                  rsp_valid_d, rsp_err_d, req_ready_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

    // Address decode and error checks on the live request
    always_comb begin
        off       = req_addr - ADDR_BASE;
        word_idx  = off >> LW;
        lane      = off[LW-1:0];
        size      = req_funct3[1:0];
        range_err = (word_idx >= 32'(DEPTH));
        case (size)
            2'd1:    align_err = off[0];
            2'd2:    align_err = (off[1:0] != 2'b00);
            2'd3:    align_err = (off[2:0] != 3'b000);
            default: align_err = 1'b0;
        endcase
        f3_err = (req_funct3 == 3'b111) ||
                 ((DATA_WIDTH == 32) && ((req_funct3 == F3_D) || (req_funct3 == F3_WU)));
        err_c  = range_err | align_err | f3_err;
    end

    // Array access only on a clean accept, never while in reset
    assign acc_c    = req_valid & req_ready & ~rst;
    assign we_c     = acc_c & req_we & ~err_c;
    assign re_c     = acc_c & ~req_we & ~err_c;
    assign be_c     = NB'(mask(size, 3'(lane)));
    assign wdata_sh = req_wdata << {lane, 3'b000};

    ram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .FILE_NAME  (FILE_NAME)
    ) u_bank (
        .clk   (clk),
        .we    (we_c),
        .be    (be_c),
        .waddr (IW'(word_idx)),
        .wdata (wdata_sh),
        .re    (re_c),
        .raddr (IW'(word_idx)),
        .rdata (bank_rdata)
    );

    // Align the raw word to the captured lane and extend to full width
    always_comb begin
        shifted = bank_rdata >> {lane_q, 3'b000};
        nb      = 8;
        msb     = shifted[7];
        case (f3_q[1:0])
            2'd0: begin nb = 8;  msb = shifted[7];  end
            2'd1: begin nb = 16; msb = shifted[15]; end
            2'd2: begin nb = 32; msb = shifted[31]; end
            default: begin nb = int'(DATA_WIDTH); msb = shifted[DATA_WIDTH-1]; end
        endcase
        fill = msb & ~f3_q[2];
        ext  = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            ext[i] = (i < nb) ? shifted[i] : fill;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            lane_q    <= '0;
            f3_q      <= '0;
        end else begin
            state     <= state_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            req_ready <= req_ready_d;
            if (acc_c) begin
                lane_q <= lane;
                f3_q   <= req_funct3;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (acc_c) state_d = (err_c || req_we) ? ST_RESP : ST_LOAD;
            ST_LOAD: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state)
            ST_IDLE: begin
                if (acc_c) begin
                    rsp_valid_d = err_c | req_we;
                    rsp_rdata_d = '0;
                    rsp_err_d   = err_c;
                end
            end
            ST_LOAD: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ext;
                rsp_err_d   = 1'b0;
            end
            ST_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: rsp_valid_d = 1'b0;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_byte_lane_ram.sv
module tb_byte_lane_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        v32 = 1'b0, we32 = 1'b0, rr32 = 1'b1;
    logic [31:0] a32 = '0, wd32 = '0;
    logic [2:0]  f32 = '0;
    logic        rdy32, rv32, er32;
    logic [31:0] rd32;

    // 64-bit instance
    logic        v64 = 1'b0, we64 = 1'b0, rr64 = 1'b1;
    logic [31:0] a64 = '0;
    logic [63:0] wd64 = '0;
    logic [2:0]  f64 = '0;
    logic        rdy64, rv64, er64;
    logic [63:0] rd64;

    int errors = 0;
    int checks = 0;

    byte_lane_ram #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_BASE(32'h0), .FILE_NAME("")) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(v32), .req_ready(rdy32), .req_we(we32), .req_addr(a32),
        .req_funct3(f32), .req_wdata(wd32),
        .rsp_valid(rv32), .rsp_ready(rr32), .rsp_rdata(rd32), .rsp_err(er32)
    );

    byte_lane_ram #(.DATA_WIDTH(64), .DEPTH(256), .ADDR_BASE(32'h0), .FILE_NAME("")) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(v64), .req_ready(rdy64), .req_we(we64), .req_addr(a64),
        .req_funct3(f64), .req_wdata(wd64),
        .rsp_valid(rv64), .rsp_ready(rr64), .rsp_rdata(rd64), .rsp_err(er64)
    );

    // One full transaction on the 32-bit instance, rsp_ready held high
    task automatic req32(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
        @(negedge clk);
        v32 = 1'b1; we32 = we; a32 = addr; f32 = f3; wd32 = wd;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0; wd32 = 32'hA5A5A5A5;
        lat = 1;
        while (!rv32 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rd32;
        er = er32;
        @(negedge clk);
    endtask

    task automatic req64(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [63:0] wd, output logic [63:0] rd, output logic er,
                         output int lat);
        @(negedge clk);
        v64 = 1'b1; we64 = we; a64 = addr; f64 = f3; wd64 = wd;
        @(posedge clk);
        @(negedge clk);
        v64 = 1'b0;
        lat = 1;
        while (!rv64 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rd64;
        er = er64;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (rv32 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rv32); end
        checks++; if (er32 !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", er32); end
        checks++; if (rd32 !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rd32); end
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", rdy32); end
        checks++; if (rdy64 !== 1'b1) begin errors++; $display("FAIL reset_req_ready64 got=%b exp=1", rdy64); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        req32(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency got=%0d exp=1", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got=%h exp=0", rd); end
        req32(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got=%b exp=0", er); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_subword;
        logic [31:0] rd; logic er; int lat;
        req32(1'b1, 32'h10, 3'b010, 32'h11223344, rd, er, lat);
        req32(1'b1, 32'h13, 3'b000, 32'hCCCCCC80, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb_err got=%b exp=0", er); end
        req32(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h80223344) begin errors++; $display("FAIL sb_lw got=%h exp=80223344", rd); end
        req32(1'b0, 32'h13, 3'b000, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got=%h exp=ffffff80", rd); end
        req32(1'b0, 32'h13, 3'b100, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got=%h exp=00000080", rd); end
        req32(1'b0, 32'h12, 3'b001, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF8022) begin errors++; $display("FAIL lh got=%h exp=ffff8022", rd); end
        req32(1'b1, 32'h14, 3'b010, 32'h0, rd, er, lat);
        req32(1'b1, 32'h16, 3'b001, 32'h5555ABCD, rd, er, lat);
        req32(1'b0, 32'h14, 3'b010, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hABCD0000) begin errors++; $display("FAIL sh_lw got=%h exp=abcd0000", rd); end
        req32(1'b0, 32'h16, 3'b101, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL lhu got=%h exp=0000abcd", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        req32(1'b0, 32'h12, 3'b010, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL lw_misaligned_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lw_misaligned_rdata got=%h exp=0", rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency got=%0d exp=1", lat); end
        req32(1'b1, 32'h11, 3'b001, 32'h0000FFFF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misaligned_err got=%b exp=1", er); end
        req32(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h80223344) begin errors++; $display("FAIL sh_misaligned_unchanged got=%h exp=80223344", rd); end
        req32(1'b0, 32'h400, 3'b010, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL lw_range_err got=%b exp=1", er); end
        req32(1'b0, 32'h3FC, 3'b010, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_last_word_err got=%b exp=0", er); end
        req32(1'b0, 32'h10, 3'b111, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL f3_111_err got=%b exp=1", er); end
        req32(1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL ld_on_32_err got=%b exp=1", er); end
    endtask

    task automatic test_backpressure;
        rr32 = 1'b0;
        @(negedge clk);
        v32 = 1'b1; we32 = 1'b0; a32 = 32'h10; f32 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        @(negedge clk);
        checks++; if (rv32 !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid_rise got=%b exp=1", rv32); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rv32 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, rv32); end
            checks++; if (rd32 !== 32'h80223344) begin errors++; $display("FAIL bp_hold_rdata cyc=%0d got=%h exp=80223344", i, rd32); end
            checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, rdy32); end
        end
        rr32 = 1'b1;
        @(negedge clk);
        checks++; if (rv32 !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", rv32); end
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", rdy32); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        v32 = 1'b1; we32 = 1'b0; a32 = 32'h10; f32 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rv32 !== 1'b0) begin errors++; $display("FAIL rst_load_valid got=%b exp=0", rv32); end
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL rst_load_ready got=%b exp=1", rdy32); end
        @(negedge clk);
        checks++; if (rv32 !== 1'b0) begin errors++; $display("FAIL rst_load_valid_later got=%b exp=0", rv32); end
        req32(1'b1, 32'h20, 3'b010, 32'h11111111, rd, er, lat);
        @(negedge clk);
        rst = 1'b1; v32 = 1'b1; we32 = 1'b1; a32 = 32'h20; f32 = 3'b010; wd32 = 32'h22222222;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; v32 = 1'b0;
        checks++; if (rv32 !== 1'b0) begin errors++; $display("FAIL rst_store_valid got=%b exp=0", rv32); end
        req32(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL rst_store_blocked got=%h exp=11111111", rd); end
    endtask

    task automatic test_wide64;
        logic [63:0] rd; logic er; int lat;
        req64(1'b1, 32'h8, 3'b011, 64'h0123456789ABCDEF, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sd_err got=%b exp=0", er); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL sd_latency got=%0d exp=1", lat); end
        req64(1'b0, 32'hC, 3'b110, 64'h0, rd, er, lat);
        checks++; if (rd !== 64'h0000000001234567) begin errors++; $display("FAIL lwu64 got=%h exp=0000000001234567", rd); end
        req64(1'b0, 32'h8, 3'b011, 64'h0, rd, er, lat);
        checks++; if (rd !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL ld64 got=%h exp=0123456789abcdef", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld64_latency got=%0d exp=2", lat); end
        req64(1'b0, 32'h8, 3'b010, 64'h0, rd, er, lat);
        checks++; if (rd !== 64'hFFFFFFFF89ABCDEF) begin errors++; $display("FAIL lw64_sext got=%h exp=ffffffff89abcdef", rd); end
        req64(1'b0, 32'hC, 3'b011, 64'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL ld64_misaligned_err got=%b exp=1", er); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_wide64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
